stoch_window_counter: RTL and testbench

- Downstream stage of the temporal stochastic bit magnifier. Consumes its serial stochastic bitstream.
- Counts ones over a fixed window of 2^WIN_LOG2 qualified samples and emits the binary estimate with a one-cycle valid strobe.
- Used at neuron outputs and at debug taps where stochastic values are converted back to binary for the host or for comparison logic.

---
 rtl/stoch_pkg.sv | 13 +
 rtl/stoch_win_ctr.sv | 29 ++
 rtl/stoch_window_counter.sv | 102 ++++++++++
 tb/tb_stoch_window_counter.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/stoch_pkg.sv
// Shared definitions for the stochastic bitstream pipeline (generator, magnifier, window counter).
package stoch_pkg;

   localparam int WIN_LOG2_DEF = 8;

   // A window of 2^w samples can hold a count of exactly 2^w, hence one extra bit.
   function automatic int cw_of(input int w);
      return w + 1;
   endfunction

   typedef logic [cw_of(WIN_LOG2_DEF)-1:0] win_cnt_t;

endpackage

// File: rtl/stoch_win_ctr.sv
// Qualified-sample counter with restart, wrap (or saturate) and last-sample flag.
module stoch_win_ctr
   import stoch_pkg::*;
#(
   parameter int W   = WIN_LOG2_DEF,
   parameter bit SAT = 1'b0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         adv,
   input  logic         restart,
   output logic [W-1:0] cnt,
   output logic         last
);

   // When saturating, last stays high on every qualified cycle once full.
   assign last = adv && (cnt == '1);

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (restart) begin
         cnt <= adv ? W'(1) : '0;
      end else if (adv && !(SAT && last)) begin
         cnt <= cnt + W'(1);
      end
   end

endmodule

// File: rtl/stoch_window_counter.sv
// Counts ones over 2^WIN_LOG2 qualified samples; SLIDING_WIN_EN selects a sliding window.
module stoch_window_counter
   import stoch_pkg::*;
#(
   parameter int WIN_LOG2 = WIN_LOG2_DEF,
   parameter int CW       = cw_of(WIN_LOG2)
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                EN,
   input  logic                IN,
   input  logic                SYNC,
   output logic [CW-1:0]       OUT,
   output logic                VALID,
   output logic [WIN_LOG2-1:0] FILL
);

`ifdef SLIDING_WIN_EN
   localparam bit SLIDE = 1'b1;
`else
   localparam bit SLIDE = 1'b0;
`endif

   logic [WIN_LOG2-1:0] smp;
   logic                last;
   logic [CW-1:0]       acc;
   logic [CW-1:0]       in_ext;

   assign in_ext = {{(CW-1){1'b0}}, IN};
   assign FILL   = smp;

   stoch_win_ctr #(
      .W   (WIN_LOG2),
      .SAT (SLIDE)
   ) u_ctr (
      .clk     (CLK),
      .rst     (RST),
      .adv     (EN),
      .restart (SYNC),
      .cnt     (smp),
      .last    (last)
   );

`ifdef SLIDING_WIN_EN
   localparam int N = 2 ** WIN_LOG2;

   logic [N-1:0]  sr;
   logic          filled;
   logic [CW-1:0] old_ext;
   logic [CW-1:0] acc_next;

   // sr[N-1] is the sample leaving the window once it has filled.
   assign old_ext  = {{(CW-1){1'b0}}, sr[N-1]};
   assign acc_next = acc + in_ext - (filled ? old_ext : '0);

   always_ff @(posedge CLK) begin
      if (RST) begin
         acc    <= '0;
         OUT    <= '0;
         VALID  <= 1'b0;
         sr     <= '0;
         filled <= 1'b0;
      end else begin
         VALID <= 1'b0;
         if (SYNC) begin
            acc    <= EN ? in_ext : '0;
            sr     <= EN ? {{(N-1){1'b0}}, IN} : '0;
            filled <= 1'b0;
         end else if (EN) begin
            acc <= acc_next;
            sr  <= {sr[N-2:0], IN};
            if (last) begin
               OUT    <= acc_next;
               VALID  <= 1'b1;
               filled <= 1'b1;
            end
         end
      end
   end
`else
   always_ff @(posedge CLK) begin
      if (RST) begin
         acc   <= '0;
         OUT   <= '0;
         VALID <= 1'b0;
      end else begin
         VALID <= 1'b0;
         // A restart discards the partial window, even on what would be its last sample.
         if (SYNC) begin
            acc <= EN ? in_ext : '0;
         end else if (last) begin
            OUT   <= acc + in_ext;
            VALID <= 1'b1;
            acc   <= '0;
         end else if (EN) begin
            acc <= acc + in_ext;
         end
      end
   end
`endif

endmodule

// File: tb/tb_stoch_window_counter.sv
// Bench for stoch_window_counter (WIN_LOG2=4): window table plus SYNC/EN/reset sequences.
module tb_stoch_window_counter;

   localparam int WL  = 4;
   localparam int CWB = 5;

   logic           CLK = 1'b0;
   logic           RST;
   logic           EN;
   logic           IN;
   logic           SYNC;
   logic [CWB-1:0] OUT;
   logic           VALID;
   logic [WL-1:0]  FILL;

   always #5 CLK = ~CLK;

   stoch_window_counter #(
      .WIN_LOG2 (WL),
      .CW       (CWB)
   ) dut (
      .CLK   (CLK),
      .RST   (RST),
      .EN    (EN),
      .IN    (IN),
      .SYNC  (SYNC),
      .OUT   (OUT),
      .VALID (VALID),
      .FILL  (FILL)
   );

   typedef struct packed {
      logic [15:0] pat;
      logic [4:0]  cnt;
   } win_vec_t;

   win_vec_t       tbl [8];
   logic [CWB-1:0] exp_q [$];
   logic [CWB-1:0] cur_out;
   int             checks;
   int             errors;

   // One clock: drive, optionally push the expected result, then check after the edge.
   task automatic step(input logic r, input logic e, input logic s, input logic i,
                       input logic vexp, input logic [CWB-1:0] vval, input int fexp,
                       input string nm);
      logic [CWB-1:0] want;
      RST = r; EN = e; SYNC = s; IN = i;
      if (vexp) exp_q.push_back(vval);
      @(posedge CLK);
      #1;
      if (r) cur_out = '0;
      checks++;
      if (VALID !== vexp) begin
         errors++;
         $display("FAIL %s valid: got %0b want %0b", nm, VALID, vexp);
      end
      if (VALID && exp_q.size() > 0) begin
         want = exp_q.pop_front();
         checks++;
         if (OUT !== want) begin
            errors++;
            $display("FAIL %s out: got %0d want %0d", nm, OUT, want);
         end
         cur_out = want;
      end else begin
         if (vexp && exp_q.size() > 0) cur_out = exp_q.pop_front();
         else begin
            checks++;
            if (OUT !== cur_out) begin
               errors++;
               $display("FAIL %s out_hold: got %0d want %0d", nm, OUT, cur_out);
            end
         end
      end
      checks++;
      if (FILL !== WL'(fexp)) begin
         errors++;
         $display("FAIL %s fill: got %0d want %0d", nm, FILL, fexp);
      end
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      cur_out = '0;
      RST = 1'b1; EN = 1'b0; IN = 1'b0; SYNC = 1'b0;

      tbl[0] = '{pat: 16'hFFFF, cnt: 5'd16};
      tbl[1] = '{pat: 16'h0000, cnt: 5'd0};
      tbl[2] = '{pat: 16'hAAAA, cnt: 5'd8};
      tbl[3] = '{pat: 16'h5555, cnt: 5'd8};
      tbl[4] = '{pat: 16'h000F, cnt: 5'd4};
      tbl[5] = '{pat: 16'h8001, cnt: 5'd2};
      tbl[6] = '{pat: 16'h1234, cnt: 5'd5};
      tbl[7] = '{pat: 16'hFFFE, cnt: 5'd15};

      step(1, 0, 0, 0, 0, 0, 0, "reset");
      step(1, 1, 0, 1, 0, 0, 0, "reset_en");
      step(0, 0, 0, 1, 0, 0, 0, "idle");

`ifdef SLIDING_WIN_EN
      for (int k = 0; k < 16; k++)
         step(0, 1, 0, 1, k == 15, 5'd16, (k < 15) ? k + 1 : 15, "slide_fill");
      for (int k = 1; k <= 16; k++)
         step(0, 1, 0, 0, 1'b1, CWB'(16 - k), 15, "slide_drain");
`else
      for (int w = 0; w < 8; w++)
         for (int k = 0; k < 16; k++)
            step(0, 1, 0, tbl[w].pat[15-k], k == 15, tbl[w].cnt, (k + 1) % 16, "window");

      // EN gaps stretch the window; IN on disabled cycles must be ignored.
      for (int c = 0; c < 32; c++) begin
         if (c % 2 == 0)
            step(0, 1, 0, 1, c == 30, 5'd16, (c / 2 + 1) % 16, "gap_en");
         else
            step(0, 0, 0, 1, 0, 0, (c / 2 + 1) % 16, "gap_hold");
      end

      // SYNC at sample 10: old window lost, SYNC sample starts the new one.
      for (int k = 0; k < 10; k++) step(0, 1, 0, 1, 0, 0, k + 1, "pre_sync");
      step(0, 1, 1, 1, 0, 0, 1, "sync_mid");
      for (int k = 2; k <= 16; k++) step(0, 1, 0, 0, k == 16, 5'd1, k % 16, "post_sync");

      // SYNC coincident with the 16th sample suppresses VALID.
      for (int k = 0; k < 15; k++) step(0, 1, 0, 1, 0, 0, k + 1, "pre_sync16");
      step(0, 1, 1, 0, 0, 0, 1, "sync_last");
      for (int k = 2; k <= 16; k++) step(0, 1, 0, 1, k == 16, 5'd15, k % 16, "after_sync16");

      // SYNC with EN low restarts at zero.
      for (int k = 0; k < 5; k++) step(0, 1, 0, 1, 0, 0, k + 1, "pre_sync_off");
      step(0, 0, 1, 1, 0, 0, 0, "sync_no_en");
      for (int k = 1; k <= 16; k++) step(0, 1, 0, 1, k == 16, 5'd16, k % 16, "after_sync_off");

      // Reset at sample 7 clears OUT and discards the partial window.
      for (int k = 0; k < 7; k++) step(0, 1, 0, 1, 0, 0, k + 1, "pre_rst");
      step(1, 1, 0, 1, 0, 0, 0, "rst_mid");
      for (int k = 1; k <= 16; k++) step(0, 1, 0, 1, k == 16, 5'd16, k % 16, "after_rst");
`endif

      step(0, 0, 0, 0, 0, 0, 0, "tail");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
